hamming_code_decoder: RTL and testbench

HAMMING_CODE_DECODER -- requirements
Module: hamming_code_decoder

---
 rtl/hamming_pkg.sv | 29 ++
 rtl/hamming_syndrome.sv | 29 ++
 rtl/hamming_code_decoder.sv | 81 ++++++++
 tb/tb_hamming_code_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared constants and types for the Hamming(7,4) decoder.
//                Bit positions are numbered 1..7; parity at 1, 2, 4 and
//                data at 3, 5, 6, 7.
//  Revision    : 1.0  initial release
// ============================================================================
package hamming_pkg;

  localparam int C_CODE_W = 7;
  localparam int C_DATA_W = 4;

  // Parity bit positions
  localparam int C_P1_POS = 1;
  localparam int C_P2_POS = 2;
  localparam int C_P4_POS = 4;

  // Data bit positions, least significant data bit first
  localparam int C_D0_POS = 3;
  localparam int C_D1_POS = 5;
  localparam int C_D2_POS = 6;
  localparam int C_D3_POS = 7;

  // {s4, s2, s1}: position of the erroneous bit, 0 = none
  typedef logic [2:0] syndrome_t;

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming_syndrome.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_syndrome
//  Description : Combinational syndrome generator for Hamming(7,4) with
//                selectable even/odd parity.
//  Revision    : 1.0  initial release
// ============================================================================
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [C_CODE_W:1] code_in,
  input  logic              parity_type,
  output syndrome_t         syndrome
);

  logic r1;
  logic r2;
  logic r4;

  // Raw parity checks; odd parity inverts every check bit
  always_comb begin
    r1 = code_in[C_P1_POS] ^ code_in[C_D0_POS] ^ code_in[C_D1_POS] ^ code_in[C_D3_POS];
    r2 = code_in[C_P2_POS] ^ code_in[C_D0_POS] ^ code_in[C_D2_POS] ^ code_in[C_D3_POS];
    r4 = code_in[C_P4_POS] ^ code_in[C_D1_POS] ^ code_in[C_D2_POS] ^ code_in[C_D3_POS];
    syndrome = {r4, r2, r1} ^ {3{parity_type}};
  end

endmodule : hamming_syndrome
`default_nettype wire

// File: rtl/hamming_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_code_decoder
//  Description : Hamming(7,4) single-error-correcting decoder with one cycle
//                of latency. Outputs hold between accepted words; out_valid
//                pulses for one cycle per accepted word.
//  Revision    : 1.0  initial release
// ============================================================================
module hamming_code_decoder
  import hamming_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [C_CODE_W:1]   code_in,
  input  logic                parity_type,
  input  logic                in_valid,
  output logic [C_DATA_W:1]   data_out,
  output logic                error,
  output syndrome_t           syndrome,
  output logic                out_valid
);

  syndrome_t            syn_w;
  logic [C_CODE_W:0]    flip_mask;
  logic [C_CODE_W:1]    corrected;

  logic [C_DATA_W:1]    data_d,  data_q;
  logic                 err_d,   err_q;
  syndrome_t            syn_d,   syn_q;
  logic                 valid_d, valid_q;

  hamming_syndrome u_syndrome (
    .code_in     (code_in),
    .parity_type (parity_type),
    .syndrome    (syn_w)
  );

  // Invert the bit named by the syndrome; a zero syndrome lands on the
  // unused bit 0 of the mask, so the word passes through untouched
  always_comb begin
    flip_mask = {{C_CODE_W{1'b0}}, 1'b1} << syn_w;
    corrected = code_in ^ flip_mask[C_CODE_W:1];
  end

  // Next-state: capture on accepted input, otherwise hold
  always_comb begin
    data_d  = data_q;
    err_d   = err_q;
    syn_d   = syn_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = {corrected[C_D3_POS], corrected[C_D2_POS],
                 corrected[C_D1_POS], corrected[C_D0_POS]};
      err_d   = (syn_w != 3'd0);
      syn_d   = syn_w;
      valid_d = 1'b1;
    end
  end

  // Output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      err_q   <= 1'b0;
      syn_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      syn_q   <= syn_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign error     = err_q;
  assign syndrome  = syn_q;
  assign out_valid = valid_q;

endmodule : hamming_code_decoder
`default_nettype wire

// File: tb/tb_hamming_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_code_decoder
//  Description : Self-checking bench for hamming_code_decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hamming_code_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:1] code_in;
  logic       parity_type;
  logic       in_valid;
  logic [4:1] data_out;
  logic       error;
  logic [2:0] syndrome;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state (what the outputs should show after the last edge)
  logic [3:0] m_data  = '0;
  logic       m_err   = 1'b0;
  logic [2:0] m_syn   = '0;
  logic       m_valid = 1'b0;

  typedef struct {
    logic [7:1] code;
    logic       pt;
    logic [3:0] data;
    logic       err;
    logic [2:0] syn;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  hamming_code_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .parity_type (parity_type),
    .in_valid    (in_valid),
    .data_out    (data_out),
    .error       (error),
    .syndrome    (syndrome),
    .out_valid   (out_valid)
  );

  // Syndrome = XOR of the indices of all set bits, inverted for odd parity
  function automatic logic [7:0] ref_decode(input logic [7:1] c, input logic pt);
    int         s;
    logic [7:1] cc;
    s  = 0;
    cc = c;
    for (int n = 1; n <= 7; n++) if (c[n]) s = s ^ n;
    if (pt) s = s ^ 7;
    if (s != 0) cc[s] = ~cc[s];
    return {cc[7], cc[6], cc[5], cc[3], (s != 0), s[2:0]};
  endfunction

  function automatic logic [7:1] encode(input logic [3:0] d, input logic pt);
    logic [7:1] c;
    int         s;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    s = 0;
    for (int n = 1; n <= 7; n++) if (c[n]) s = s ^ n;
    if (pt) s = s ^ 7;
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, update model at the edge, sample after it
  task automatic cycle(input logic r, input logic v, input logic [7:1] c, input logic pt);
    logic [7:0] res;
    @(negedge clk);
    rst = r; in_valid = v; code_in = c; parity_type = pt;
    @(posedge clk);
    #1;
    if (r) begin
      m_data = '0; m_err = 1'b0; m_syn = '0; m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        res    = ref_decode(c, pt);
        m_data = res[7:4];
        m_err  = res[3];
        m_syn  = res[2:0];
      end
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"},  32'(data_out),  32'(m_data));
    chk({tag, ".err"},   32'(error),     32'(m_err));
    chk({tag, ".syn"},   32'(syndrome),  32'(m_syn));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
  endtask

  initial begin
    logic [7:1] cw;
    logic [3:0] held_data;

    vecs[0] = '{code: 7'b1011011, pt: 1'b0, data: 4'b1000, err: 1'b1, syn: 3'd5};
    vecs[1] = '{code: 7'b1010110, pt: 1'b1, data: 4'b1011, err: 1'b1, syn: 3'd4};
    vecs[2] = '{code: 7'b1010101, pt: 1'b0, data: 4'b1011, err: 1'b0, syn: 3'd0};
    vecs[3] = '{code: 7'b1010101, pt: 1'b1, data: 4'b0011, err: 1'b1, syn: 3'd7};

    rst = 1'b1; in_valid = 1'b1; code_in = 7'b1011011; parity_type = 1'b0;

    // Reset with in_valid high: input discarded, all outputs zero
    cycle(1'b1, 1'b1, 7'b1011011, 1'b0);
    cycle(1'b1, 1'b1, 7'b1111111, 1'b1);
    chk("reset.data",  32'(data_out),  32'h0);
    chk("reset.err",   32'(error),     32'h0);
    chk("reset.syn",   32'(syndrome),  32'h0);
    chk("reset.valid", 32'(out_valid), 32'h0);

    // Table of known vectors, back-to-back
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, vecs[i].code, vecs[i].pt);
      chk($sformatf("vec%0d.data", i),  32'(data_out),  32'(vecs[i].data));
      chk($sformatf("vec%0d.err", i),   32'(error),     32'(vecs[i].err));
      chk($sformatf("vec%0d.syn", i),   32'(syndrome),  32'(vecs[i].syn));
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'h1);
    end

    // Gap: outputs hold the last word, out_valid drops
    cycle(1'b0, 1'b0, 7'b0000000, 1'b0);
    chk("gap.data",  32'(data_out),  32'(vecs[3].data));
    chk("gap.syn",   32'(syndrome),  32'(vecs[3].syn));
    chk("gap.valid", 32'(out_valid), 32'h0);

    // Exhaustive: every data value, both parities, no flip or one flipped bit
    for (int pt = 0; pt < 2; pt++) begin
      for (int d = 0; d < 16; d++) begin
        for (int f = 0; f < 8; f++) begin
          cw = encode(4'(d), 1'(pt));
          if (f != 0) cw[f] = ~cw[f];
          cycle(1'b0, 1'b1, cw, 1'(pt));
          chk($sformatf("exh p%0d d%0d f%0d data", pt, d, f), 32'(data_out), 32'(d));
          chk($sformatf("exh p%0d d%0d f%0d err", pt, d, f), 32'(error), 32'(f != 0));
          chk($sformatf("exh p%0d d%0d f%0d syn", pt, d, f), 32'(syndrome), 32'(f));
          chk($sformatf("exh p%0d d%0d f%0d valid", pt, d, f), 32'(out_valid), 32'h1);
        end
      end
    end

    // Control sequence: reset mid-stream, then pulses with gaps
    cycle(1'b0, 1'b1, 7'b1011011, 1'b0);
    cycle(1'b1, 1'b1, 7'b1010110, 1'b1);
    chk("ctl.rst.data",  32'(data_out),  32'h0);
    chk("ctl.rst.err",   32'(error),     32'h0);
    chk("ctl.rst.syn",   32'(syndrome),  32'h0);
    chk("ctl.rst.valid", 32'(out_valid), 32'h0);
    cycle(1'b0, 1'b0, 7'b1111111, 1'b0);
    chk("ctl.idle.data",  32'(data_out),  32'h0);
    chk("ctl.idle.valid", 32'(out_valid), 32'h0);
    cycle(1'b0, 1'b1, 7'b1011011, 1'b0);
    chk("ctl.p1.data",  32'(data_out),  32'h8);
    chk("ctl.p1.valid", 32'(out_valid), 32'h1);
    held_data = data_out;
    for (int g = 0; g < 3; g++) begin
      cycle(1'b0, 1'b0, 7'(g * 37), 1'(g));
      chk($sformatf("ctl.hold%0d.data", g),  32'(data_out),  32'(held_data));
      chk($sformatf("ctl.hold%0d.syn", g),   32'(syndrome),  32'h5);
      chk($sformatf("ctl.hold%0d.err", g),   32'(error),     32'h1);
      chk($sformatf("ctl.hold%0d.valid", g), 32'(out_valid), 32'h0);
    end
    cycle(1'b0, 1'b1, 7'b1010110, 1'b1);
    chk("ctl.p2.data",  32'(data_out),  32'hB);
    chk("ctl.p2.syn",   32'(syndrome),  32'h4);
    chk("ctl.p2.valid", 32'(out_valid), 32'h1);
    cycle(1'b0, 1'b0, 7'b0, 1'b0);
    chk("ctl.p2gap.valid", 32'(out_valid), 32'h0);

    // Random traffic with random gaps and occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom), 7'($urandom), 1'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hamming_code_decoder
`default_nettype wire
